// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-stage load/store unit.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response channel between the LSU (master) and data memory (slave).
interface mem_stage_lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Sub-word lane steering: store byte enables / lane replication, load extract and extend.
// Present only when LSU_SUBWORD_EN is defined.
`ifdef LSU_SUBWORD_EN
module lsu_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_raw,
  output logic        misalign_c,
  output logic [3:0]  be_c,
  output logic [31:0] store_lanes_c,
  output logic [31:0] load_data_c
);

  logic [15:0] shifted;

  // Addressed lane moved down to bit 0 for extraction.
  assign shifted = 16'(load_raw >> {addr_lo, 3'b000});

  always_comb begin
    misalign_c    = 1'b0;
    be_c          = BE_WORD;
    store_lanes_c = store_data;
    load_data_c   = load_raw;
    case (mem_size_e'(size))
      MEM_BYTE: begin
        be_c          = 4'(BE_BYTE << addr_lo);
        store_lanes_c = {4{store_data[7:0]}};
        load_data_c   = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
      end
      MEM_HALF: begin
        misalign_c    = addr_lo[0];
        be_c          = 4'(BE_HALF << addr_lo);
        store_lanes_c = {2{store_data[15:0]}};
        load_data_c   = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
      end
      default: misalign_c = (addr_lo != 2'b00);
    endcase
  end

endmodule
`endif

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: single-outstanding data-memory access with pipeline stall.
// Optional sub-word support via LSU_SUBWORD_EN; otherwise all accesses are whole words.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemSignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        MisalignM,
  output logic        BusErrM,
  mem_stage_lsu_if.master dmem
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  lsu_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic             access;
  logic             misalign;
  logic             timeout_hit;
  logic [3:0]       be;
  logic [31:0]      wdata_lane;
  logic [31:0]      load_data;

  assign access      = MemReadM | MemWriteM;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(CNT_LAST));

`ifdef LSU_SUBWORD_EN
  lsu_lane_align u_lane_align (
    .size          (MemSizeM),
    .sign_ext      (MemSignedM),
    .addr_lo       (ALUOutM[1:0]),
    .store_data    (WriteDataM),
    .load_raw      (dmem.rsp_rdata),
    .misalign_c    (misalign),
    .be_c          (be),
    .store_lanes_c (wdata_lane),
    .load_data_c   (load_data)
  );
`else
  logic unused_size;
  assign unused_size = ^{MemSizeM, MemSignedM};
  assign misalign    = (ALUOutM[1:0] != 2'b00);
  assign be          = BE_WORD;
  assign wdata_lane  = WriteDataM;
  assign load_data   = dmem.rsp_rdata;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; both read and write set resolves to a store.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (access && !misalign) state_nxt = REQ;
      REQ:     if (dmem.req_ready) state_nxt = MemWriteM ? DONE : WAIT;
      WAIT:    if (dmem.rsp_valid || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; stall must rise in the same cycle the access appears.
  always_comb begin
    StallMem       = 1'b0;
    MisalignM      = 1'b0;
    BusErrM        = 1'b0;
    dmem.req_valid = 1'b0;
    case (state)
      IDLE: begin
        StallMem  = access & ~misalign;
        MisalignM = access & misalign;
      end
      REQ: begin
        StallMem       = 1'b1;
        dmem.req_valid = 1'b1;
      end
      WAIT:    StallMem = 1'b1;
      DONE:    BusErrM  = err;
      default: ;
    endcase
    if (reset) begin
      StallMem  = 1'b0;
      MisalignM = 1'b0;
      BusErrM   = 1'b0;
    end
  end

  assign dmem.req_we    = MemWriteM;
  assign dmem.req_addr  = {ALUOutM[31:2], 2'b00};
  assign dmem.req_wdata = wdata_lane;
  assign dmem.req_be    = be;

  // Load result, wait counter and timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadDataM <= 32'h0;
      cnt       <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (dmem.rsp_valid) begin
            ReadDataM <= load_data;
          end else if (timeout_hit) begin
            ReadDataM <= 32'h0;
            err       <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cnt <= '0;
          err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
